// File: rtl/drive_cmd_ctrl.sv
// rtl/drive_cmd_ctrl.sv - debounced DIP-switch drive command FSM with STOP dwell on GO<->BACK reversal
// Optional feature macro: ILLEGAL_FORCE_STOP_EN (illegal debounced code forces STOP and RUN)
module drive_cmd_ctrl #(
  parameter int DEB_NUM = 1_000_000,
  parameter int GAP_NUM = 25_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] sw_in,
  output logic [3:0] state_out,
  output logic       state_chg,
  output logic       illegal
);
  localparam int DW = (DEB_NUM > 1) ? $clog2(DEB_NUM) : 1;
  localparam int GW = (GAP_NUM > 1) ? $clog2(GAP_NUM) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_NUM - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_NUM - 1);
  localparam logic [3:0] C_STOP = 4'b0000;
  localparam logic [3:0] C_GO   = 4'b0001;
  localparam logic [3:0] C_BACK = 4'b1000;

  typedef enum logic {RUN, GAP} fsm_t;

  logic [3:0]    sync1_q, sync2_q, prev_q;
  logic [3:0]    deb_q, deb_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [GW-1:0] gap_cnt_q;
  fsm_t          fsm_q;
  logic [3:0]    state_q;
  logic          chg_q, illegal_q;
  logic          deb_legal, reversal;

  function automatic logic is_legal(input logic [3:0] c);
    case (c)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: is_legal = 1'b1;
      default:                                     is_legal = 1'b0;
    endcase
  endfunction

  assign deb_legal = is_legal(deb_q);
  assign reversal  = ((state_q == C_GO) && (deb_q == C_BACK)) ||
                     ((state_q == C_BACK) && (deb_q == C_GO));

  // Counter runs only while the synchronized code is steady and differs from the debounced one.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q + DW'(1);
    if ((sync2_q != prev_q) || (sync2_q == deb_q)) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      deb_d     = sync2_q;
      deb_cnt_d = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      deb_q     <= '0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q   <= sw_in;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      fsm_q     <= RUN;
      state_q   <= C_STOP;
      chg_q     <= 1'b0;
      illegal_q <= 1'b0;
      gap_cnt_q <= '0;
    end else begin
      chg_q     <= 1'b0;
      illegal_q <= !deb_legal;
      case (fsm_q)
        RUN: begin
`ifdef ILLEGAL_FORCE_STOP_EN
          if (!deb_legal) begin
            state_q <= C_STOP;
            chg_q   <= (state_q != C_STOP);
          end else
`endif
          if (deb_legal && (deb_q != state_q)) begin
            chg_q <= 1'b1;
            if (reversal) begin
              state_q   <= C_STOP;
              gap_cnt_q <= '0;
              fsm_q     <= GAP;
            end else begin
              state_q <= deb_q;
            end
          end
        end
        GAP: begin
          // state_q is STOP throughout the dwell, so only a non-STOP target pulses.
`ifdef ILLEGAL_FORCE_STOP_EN
          if (!deb_legal) begin
            state_q <= C_STOP;
            fsm_q   <= RUN;
          end else
`endif
          if (deb_q == C_STOP) begin
            fsm_q <= RUN;
          end else if (gap_cnt_q == GAP_LAST) begin
            state_q <= deb_legal ? deb_q : C_STOP;
            chg_q   <= deb_legal;
            fsm_q   <= RUN;
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end
        default: fsm_q <= RUN;
      endcase
    end
  end

  assign state_out = state_q;
  assign state_chg = chg_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_drive_cmd_ctrl.sv
// tb/tb_drive_cmd_ctrl.sv - scoreboard bench for drive_cmd_ctrl against a behavioural model
module tb_drive_cmd_ctrl;
  localparam int DEB = 4;
  localparam int GAP = 8;
  localparam int HL  = DEB + 3;

  logic       clk = 1'b0;
  logic       sys_rst_n;
  logic [3:0] sw_in;
  logic [3:0] state_out;
  logic       state_chg;
  logic       illegal;

  int total = 0;
  int bad = 0;
  int chg_seen = 0;
  int base;

  logic [5:0] exp_q[$];
  logic [3:0] hist[$];
  logic [3:0] m_deb, m_state;
  bit         m_gap;
  int         gap_left;
  logic [3:0] codes[5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

  always #5 clk = ~clk;

  drive_cmd_ctrl #(.DEB_NUM(DEB), .GAP_NUM(GAP)) dut (
    .sys_clk   (clk),
    .sys_rst_n (sys_rst_n),
    .sw_in     (sw_in),
    .state_out (state_out),
    .state_chg (state_chg),
    .illegal   (illegal)
  );

  function automatic bit legal(input logic [3:0] c);
    return c inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Debounced code = a synchronized value seen DEB+1 samples in a row that differs from the current one.
  task automatic model_loop();
    logic [3:0] d, s, nv;
    bit stable, chg, ill;
    forever begin
      @(posedge clk);
      if (!sys_rst_n) begin
        m_deb = 4'b0; m_state = 4'b0; m_gap = 0; gap_left = 0;
        hist.delete();
        for (int i = 0; i < HL; i++) hist.push_back(4'b0);
        exp_q.push_back(6'b0);
      end else begin
        d = m_deb;
        ill = !legal(d);
        chg = 0;
        if (m_gap) begin
`ifdef ILLEGAL_FORCE_STOP_EN
          if (ill) m_gap = 0; else
`endif
          if (d == 4'b0000) m_gap = 0;
          else begin
            gap_left--;
            if (gap_left == 0) begin
              nv = ill ? 4'b0000 : d;
              chg = (nv != m_state);
              m_state = nv;
              m_gap = 0;
            end
          end
        end else begin
`ifdef ILLEGAL_FORCE_STOP_EN
          if (ill) begin
            chg = (m_state != 4'b0000);
            m_state = 4'b0000;
          end else
`endif
          if (!ill && d != m_state) begin
            chg = 1;
            if ((m_state == 4'b0001 && d == 4'b1000) || (m_state == 4'b1000 && d == 4'b0001)) begin
              m_state = 4'b0000;
              m_gap = 1;
              gap_left = GAP;
            end else begin
              m_state = d;
            end
          end
        end
        s = hist[HL-2];
        stable = 1;
        for (int i = 1; i <= HL - 2; i++) if (hist[i] != s) stable = 0;
        if (stable && s != m_deb) m_deb = s;
        void'(hist.pop_front());
        hist.push_back(sw_in);
        exp_q.push_back({m_state, chg, ill});
      end
    end
  endtask

  task automatic monitor_loop();
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({state_out, state_chg, illegal} !== e) begin
          bad++;
          $display("FAIL scoreboard t=%0t: got so=%b chg=%b ill=%b expected so=%b chg=%b ill=%b",
                   $time, state_out, state_chg, illegal, e[5:2], e[1], e[0]);
        end
        if (state_chg === 1'b1) chg_seen++;
      end
    end
  endtask

  task automatic drive(input logic [3:0] sw, input logic rst_n, input int n);
    for (int i = 0; i < n; i++) begin
      sw_in = sw;
      sys_rst_n = rst_n;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int r, n;
    logic [3:0] c;
    sw_in = 4'b0;
    sys_rst_n = 1'b0;
    fork
      model_loop();
      monitor_loop();
    join_none
    @(posedge clk);
    #1;
    drive(4'b0000, 1'b0, 3);
    settle();
    check("reset_outputs", int'({state_out, state_chg, illegal}), 0);

    base = chg_seen;
    drive(4'b0010, 1'b1, 2);
    drive(4'b0000, 1'b1, 10);
    settle();
    check("glitch_chg", chg_seen - base, 0);
    check("glitch_state", int'(state_out), 0);
    check("glitch_illegal", int'(illegal), 0);

    base = chg_seen;
    drive(4'b0001, 1'b1, DEB + 2);
    settle();
    check("go_before_latency", int'(state_out), 0);
    drive(4'b0001, 1'b1, 2);
    settle();
    check("go_state", int'(state_out), 1);
    check("go_chg", chg_seen - base, 1);

    base = chg_seen;
    drive(4'b1000, 1'b1, DEB + 5);
    settle();
    check("rev_gap_stop", int'(state_out), 0);
    drive(4'b1000, 1'b1, GAP + 1);
    settle();
    check("rev_back_state", int'(state_out), 8);
    check("rev_chg", chg_seen - base, 2);

    drive(4'b0001, 1'b1, 20);
    base = chg_seen;
    drive(4'b1000, 1'b1, 7);
    drive(4'b0000, 1'b1, 12);
    settle();
    check("gap_abort_state", int'(state_out), 0);
    check("gap_abort_chg", chg_seen - base, 1);

    drive(4'b0010, 1'b1, 12);
    base = chg_seen;
    drive(4'b0011, 1'b1, 12);
    settle();
    check("illegal_flag", int'(illegal), 1);
`ifdef ILLEGAL_FORCE_STOP_EN
    check("illegal_state", int'(state_out), 0);
    check("illegal_chg", chg_seen - base, 1);
`else
    check("illegal_state", int'(state_out), 2);
    check("illegal_chg", chg_seen - base, 0);
`endif

    drive(4'b0001, 1'b1, 12);
    drive(4'b1000, 1'b1, 9);
    drive(4'b1000, 1'b0, 1);
    settle();
    check("midgap_reset", int'({state_out, state_chg, illegal}), 0);
    base = chg_seen;
    drive(4'b1000, 1'b1, DEB + 5);
    settle();
    check("post_reset_back", int'(state_out), 8);
    check("post_reset_chg", chg_seen - base, 1);

    for (int k = 0; k < 250; k++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        drive(sw_in, 1'b0, $urandom_range(1, 2));
      end else begin
        if (r < 75) c = codes[$urandom_range(0, 4)];
        else c = 4'($urandom);
        if (r >= 90) n = $urandom_range(1, DEB);
        else n = $urandom_range(DEB + 3, 20);
        drive(c, 1'b1, n);
      end
    end

    drive(4'b0000, 1'b1, 2);
    settle();
    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
